id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage sitting directly upstream of the execute stage. Holds the 32×32 integer register file and decodes one RV32I instruction per cycle into the execute stage's operand bundle: optype, data1/data2, rs1/rs2/rd, immediate, offset and pc. It registers that bundle as the ID/EX pipeline register, writes back execute results, and squashes to a bubble on a branch-mispredict clear.

## Interface
Parameters:
- none. Register count 32, XLEN 32, fixed.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-low (rst==0 resets on the clock edge)
- inst_valid  in  1  fetch presents a valid instruction this cycle
- inst  in  32  instruction word
- pc  in  32  address of inst
- clr  in  1  mispredict flush from execute
- we_reg  in  1  execute writes the register file
- wb_rd  in  5  write-back destination (execute's rd_d1)
- wb_data  in  32  write-back value (execute's res)
- optype  out  5  decoded operation, registered
- data1, data2  out  32  rs1/rs2 register values, registered
- rs1, rs2, rd  out  5  register indices, registered
- immediate  out  32  I/U-type immediate, registered
- offset  out  32  load/store/branch/jump offset, registered
- pc_d1  out  32  pc of the bundle, registered
- illegal  out  1  bundle came from an undecodable valid instruction, registered

## Operation
- optype encoding: 0 NOP, 1 LUI, 2 AUIPC, 3 JAL, 4 LW, 5 SW, 6 JALR, 7 BEQ, 8 BNE, 9 BLT, 10 BGE, 11 BLTU, 12 BGEU, 13 ADDI, 14 SLTI, 15 SLTIU, 16 XORI, 17 ORI, 18 ANDI, 19 SLLI, 20 SRLI, 21 SRAI, 22 ADD, 23 SUB, 24 SLL, 25 SLT, 26 SLTU, 27 XOR, 28 SRL, 29 SRA, 30 OR, 31 AND.
- immediate:
  - I-type ALU ops: sign-extended imm[11:0].
  - Shifts: zero-extended shamt.
  - LUI/AUIPC: inst[31:12]<<12.
- offset:
  - LW, JALR: sign-extended I immediate.
  - SW: S immediate.
  - Branches: B immediate.
  - JAL: J immediate.
- Unused immediate/offset fields are 0.
- rs1/rs2/rd carry instruction fields only when the op uses them; otherwise 0. rd is 0 for SW and for branches.
- Register file:
  - x0 reads 0 always; writes to x0 are ignored.
  - Write when we_reg=1 and wb_rd!=0.
  - Same-cycle bypass: if wb_rd matches a read index while we_reg=1 and the index is nonzero, data1/data2 capture wb_data.
- Invalid encoding (unknown opcode/funct3/funct7, any LB/LH/SB etc.): registers a NOP bundle with illegal=1.
- Bubble (inst_valid=0, or clr=1): optype=0, all indices/data/immediate/offset=0, illegal=0, pc_d1=0.
- Priority: reset > clr > inst_valid. The register-file write still happens in a clr cycle.

## Timing
- Latency 1: fields of inst sampled at edge N appear on outputs after edge N.
- Write-back is committed at the same edge; a read in cycle N+1 sees it.
- No stall input; a new bundle is issued every cycle.
- Reset (rst=0 at an edge): all outputs 0, all 32 registers cleared to 0. Any in-flight write-back in that cycle is dropped.
- Reset asserted mid-stream discards the current bundle; the first post-reset bundle comes from the first edge with rst=1.

## Test plan
- Reset: rst=0 for 2 cycles, then read x1..x31 via ADD instructions → every data1/data2 reads 0; all outputs 0 during reset.
- Decode I-type: inst=0x00500093 (ADDI x1,x0,5), pc=0x100 → next cycle optype=13, rd=1, rs1=0, immediate=5, pc_d1=0x100, data1=0.
- Bypass:
  - Setup: write x1=7, x2=9 via we_reg.
  - Present inst=0x002081B3 (ADD x3,x1,x2) in the same cycle as we_reg=1, wb_rd=2, wb_data=0x33.
  - Response: optype=22, rd=3, data1=7, data2=0x33.
- Load: inst=0x0080A283 (LW x5,8(x1)), x1=0x1000 → optype=4, rd=5, rs1=1, offset=8, data1=0x1000, immediate=0.
- Flush and x0:
  - clr=1 with a valid ADDI → NOP bundle, while a concurrent write x4=0xAB commits (later read of x4 = 0xAB).
  - we_reg=1, wb_rd=0, wb_data=0xFF → later read of x0 = 0.
- Illegal: inst=0x00000000 with inst_valid=1 → optype=0, illegal=1. The next valid ADDI clears illegal to 0.

Source files
------------

// File: rtl/id_stage.sv
// RV32I decode stage: register file, instruction decode and the ID/EX pipeline register.
// Bubbles are issued for idle fetch, mispredict flush, and reset.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic        clr,
  input  logic        we_reg,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [4:0]  optype,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] immediate,
  output logic [31:0] offset,
  output logic [31:0] pc_d1,
  output logic        illegal
);

  typedef struct packed {
    logic [4:0]  optype;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] immediate;
    logic [31:0] offset;
    logic        illegal;
  } dec_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0] regs [32];
  dec_t        d;
  logic        legal;
  logic [31:0] rdata1, rdata2;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign shamt  = {27'b0, inst[24:20]};

  always_comb begin
    d     = '0;
    legal = 1'b1;
    case (opcode)
      OPC_LUI:   begin d.optype = 5'd1; d.rd = inst[11:7]; d.immediate = imm_u; end
      OPC_AUIPC: begin d.optype = 5'd2; d.rd = inst[11:7]; d.immediate = imm_u; end
      OPC_JAL:   begin d.optype = 5'd3; d.rd = inst[11:7]; d.offset = imm_j; end
      OPC_JALR: begin
        d.optype = 5'd6; d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.offset = imm_i;
        legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.offset = imm_b;
        case (funct3)
          3'b000:  d.optype = 5'd7;
          3'b001:  d.optype = 5'd8;
          3'b100:  d.optype = 5'd9;
          3'b101:  d.optype = 5'd10;
          3'b110:  d.optype = 5'd11;
          3'b111:  d.optype = 5'd12;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        d.optype = 5'd4; d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.offset = imm_i;
        legal = (funct3 == 3'b010);
      end
      OPC_STORE: begin
        d.optype = 5'd5; d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.offset = imm_s;
        legal = (funct3 == 3'b010);
      end
      OPC_OPIMM: begin
        d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.immediate = imm_i;
        case (funct3)
          3'b000: d.optype = 5'd13;
          3'b010: d.optype = 5'd14;
          3'b011: d.optype = 5'd15;
          3'b100: d.optype = 5'd16;
          3'b110: d.optype = 5'd17;
          3'b111: d.optype = 5'd18;
          3'b001: begin d.optype = 5'd19; d.immediate = shamt; legal = (funct7 == 7'b0000000); end
          default: begin
            d.immediate = shamt;
            if (funct7 == 7'b0000000)      d.optype = 5'd20;
            else if (funct7 == 7'b0100000) d.optype = 5'd21;
            else                           legal = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.rs2 = inst[24:20];
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  d.optype = 5'd22;
            3'b001:  d.optype = 5'd24;
            3'b010:  d.optype = 5'd25;
            3'b011:  d.optype = 5'd26;
            3'b100:  d.optype = 5'd27;
            3'b101:  d.optype = 5'd28;
            3'b110:  d.optype = 5'd30;
            default: d.optype = 5'd31;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) d.optype = 5'd23;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101)     d.optype = 5'd29;
        else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d         = '0;
      d.illegal = 1'b1;
    end
  end

  // Reads use the decoded indices, so unused operands naturally read x0 = 0.
  always_comb begin
    rdata1 = regs[d.rs1];
    rdata2 = regs[d.rs2];
    if (d.rs1 == 5'd0)                   rdata1 = '0;
    else if (we_reg && wb_rd == d.rs1)   rdata1 = wb_data;
    if (d.rs2 == 5'd0)                   rdata2 = '0;
    else if (we_reg && wb_rd == d.rs2)   rdata2 = wb_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we_reg && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clr || !inst_valid) begin
      optype    <= '0;
      data1     <= '0;
      data2     <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      immediate <= '0;
      offset    <= '0;
      pc_d1     <= '0;
      illegal   <= 1'b0;
    end else begin
      optype    <= d.optype;
      data1     <= rdata1;
      data2     <= rdata2;
      rs1       <= d.rs1;
      rs2       <= d.rs2;
      rd        <= d.rd;
      immediate <= d.immediate;
      offset    <= d.offset;
      pc_d1     <= pc;
      illegal   <= d.illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode formats, bypass, flush, x0 and illegal handling.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst, inst_valid, clr, we_reg;
  logic [31:0] inst, pc, wb_data;
  logic [4:0]  wb_rd;
  logic [4:0]  optype, rs1, rs2, rd;
  logic [31:0] data1, data2, immediate, offset, pc_d1;
  logic        illegal;
  int          checks = 0;
  int          errors = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc), .clr(clr),
    .we_reg(we_reg), .wb_rd(wb_rd), .wb_data(wb_data), .optype(optype),
    .data1(data1), .data2(data2), .rs1(rs1), .rs2(rs2), .rd(rd),
    .immediate(immediate), .offset(offset), .pc_d1(pc_d1), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic cyc(input logic v, input logic [31:0] i, input logic [31:0] p, input logic c,
                     input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    inst_valid = v; inst = i; pc = p; clr = c; we_reg = we; wb_rd = wrd; wb_data = wd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return {7'b0, b, a, 3'b000, d, 7'b0110011};
  endfunction

  initial begin
    rst = 1'b0;
    // Reset with a live instruction and a write-back that must both be dropped.
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 32'h00500093, 32'h40, 1'b0, 1'b1, 5'd1, 32'h55);
      chk("rst_optype", {27'b0, optype}, 32'd0);
      chk("rst_rd", {27'b0, rd}, 32'd0);
      chk("rst_imm", immediate, 32'd0);
      chk("rst_pc", pc_d1, 32'd0);
      chk("rst_illegal", {31'b0, illegal}, 32'd0);
    end
    rst = 1'b1;

    for (int k = 1; k < 32; k++) begin
      cyc(1'b1, r_add(5'(k), 5'(k), 5'(32 - k)), 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("rst_read_d1", data1, 32'd0);
      chk("rst_read_d2", data2, 32'd0);
    end

    cyc(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("addi_optype", {27'b0, optype}, 32'd13);
    chk("addi_rd", {27'b0, rd}, 32'd1);
    chk("addi_rs1", {27'b0, rs1}, 32'd0);
    chk("addi_imm", immediate, 32'd5);
    chk("addi_pc", pc_d1, 32'h100);
    chk("addi_d1", data1, 32'd0);

    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'd7);
    chk("idle_optype", {27'b0, optype}, 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'd9);
    cyc(1'b1, 32'h002081B3, 32'h104, 1'b0, 1'b1, 5'd2, 32'h33);
    chk("byp_optype", {27'b0, optype}, 32'd22);
    chk("byp_rd", {27'b0, rd}, 32'd3);
    chk("byp_rs2", {27'b0, rs2}, 32'd2);
    chk("byp_d1", data1, 32'd7);
    chk("byp_d2", data2, 32'h33);
    cyc(1'b1, r_add(5'd3, 5'd2, 5'd1), 32'h108, 1'b0, 1'b1, 5'd1, 32'h1000);
    chk("byp_commit_x2", data1, 32'h33);

    cyc(1'b1, 32'h0080A283, 32'h10C, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("lw_optype", {27'b0, optype}, 32'd4);
    chk("lw_rd", {27'b0, rd}, 32'd5);
    chk("lw_rs1", {27'b0, rs1}, 32'd1);
    chk("lw_rs2", {27'b0, rs2}, 32'd0);
    chk("lw_off", offset, 32'd8);
    chk("lw_d1", data1, 32'h1000);
    chk("lw_imm", immediate, 32'd0);

    // SW x2,12(x1)
    cyc(1'b1, {7'b0, 5'd2, 5'd1, 3'b010, 5'd12, 7'b0100011}, 32'h110, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("sw_optype", {27'b0, optype}, 32'd5);
    chk("sw_rd", {27'b0, rd}, 32'd0);
    chk("sw_off", offset, 32'd12);
    chk("sw_d2", data2, 32'h33);

    // BEQ x1,x2,-4
    cyc(1'b1, {1'b1, 6'b111111, 5'd2, 5'd1, 3'b000, 4'b1110, 1'b1, 7'b1100011}, 32'h114, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("beq_optype", {27'b0, optype}, 32'd7);
    chk("beq_off", offset, 32'hFFFFFFFC);
    chk("beq_rd", {27'b0, rd}, 32'd0);

    // JAL x1,+0x800
    cyc(1'b1, {1'b0, 10'b0, 1'b1, 8'b0, 5'd1, 7'b1101111}, 32'h118, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("jal_optype", {27'b0, optype}, 32'd3);
    chk("jal_off", offset, 32'h800);
    chk("jal_rs1", {27'b0, rs1}, 32'd0);

    // SRAI x8,x1,31
    cyc(1'b1, {7'b0100000, 5'd31, 5'd1, 3'b101, 5'd8, 7'b0010011}, 32'h11C, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("srai_optype", {27'b0, optype}, 32'd21);
    chk("srai_imm", immediate, 32'd31);

    // LUI x9,0xABCDE
    cyc(1'b1, {20'hABCDE, 5'd9, 7'b0110111}, 32'h120, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("lui_optype", {27'b0, optype}, 32'd1);
    chk("lui_imm", immediate, 32'hABCDE000);
    chk("lui_rs1", {27'b0, rs1}, 32'd0);

    // ADDI x10,x0,-1
    cyc(1'b1, {12'hFFF, 5'd0, 3'b000, 5'd10, 7'b0010011}, 32'h124, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("addi_neg_imm", immediate, 32'hFFFFFFFF);

    cyc(1'b1, 32'h00500093, 32'h200, 1'b1, 1'b1, 5'd4, 32'hAB);
    chk("clr_optype", {27'b0, optype}, 32'd0);
    chk("clr_rd", {27'b0, rd}, 32'd0);
    chk("clr_imm", immediate, 32'd0);
    chk("clr_pc", pc_d1, 32'd0);
    chk("clr_illegal", {31'b0, illegal}, 32'd0);
    cyc(1'b1, r_add(5'd6, 5'd4, 5'd0), 32'h204, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("clr_wb_x4", data1, 32'hAB);
    chk("clr_x0_d2", data2, 32'd0);

    cyc(1'b1, r_add(5'd7, 5'd0, 5'd0), 32'h208, 1'b0, 1'b1, 5'd0, 32'hFF);
    chk("x0_nobypass", data1, 32'd0);
    cyc(1'b1, r_add(5'd7, 5'd0, 5'd0), 32'h20C, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("x0_read", data1, 32'd0);

    cyc(1'b1, 32'h00000000, 32'h300, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("ill_optype", {27'b0, optype}, 32'd0);
    chk("ill_flag", {31'b0, illegal}, 32'd1);
    chk("ill_rd", {27'b0, rd}, 32'd0);
    cyc(1'b1, 32'h00500093, 32'h304, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("ill_clear", {31'b0, illegal}, 32'd0);
    chk("ill_next_optype", {27'b0, optype}, 32'd13);

    // Mid-stream reset discards the bundle and the register contents.
    rst = 1'b0;
    cyc(1'b1, r_add(5'd3, 5'd1, 5'd4), 32'h308, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("mid_rst_optype", {27'b0, optype}, 32'd0);
    rst = 1'b1;
    cyc(1'b1, r_add(5'd3, 5'd1, 5'd4), 32'h30C, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("post_rst_optype", {27'b0, optype}, 32'd22);
    chk("post_rst_x1", data1, 32'd0);
    chk("post_rst_x4", data2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
